cache_mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache. Owns the single port of the shared multi-cycle main memory.
- Grants the memory to one cache at a time:
  - an 8-word fill burst for either cache, or
  - a single-word write for the D-cache.
- Routes returning read data and its valid back to the granted cache only.
- The caches see the arbiter exactly as they would see a private memory: they hold their request and stall until their data_valid pulses arrive.

---
 rtl/cache_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle memory port between the I-cache and D-cache.
// Grants whole 8-word fills or single D-cache writes; ties alternate via last_grant.
module cache_mem_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_data_valid,
  output logic              d_wr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, D_WRITE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             last_d_q, last_d_d;  // 1: last tie went to the D-cache

  logic granted_req;
  logic in_burst;
  logic issue_en;

  assign granted_req = (state_q == I_BURST) ? i_req : d_req;
  assign in_burst    = (state_q == I_BURST) || (state_q == D_BURST);
  assign issue_en    = in_burst && granted_req && (issue_q < CNT_MAX);

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    ret_d    = ret_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        issue_d = '0;
        ret_d   = '0;
        if (i_req && d_req) begin
          if (last_d_q) begin
            state_d  = I_BURST;
            last_d_d = 1'b0;
          end else begin
            state_d  = d_wr ? D_WRITE : D_BURST;
            last_d_d = 1'b1;
          end
        end else if (d_req) begin
          state_d = d_wr ? D_WRITE : D_BURST;
        end else if (i_req) begin
          state_d = I_BURST;
        end
      end
      I_BURST, D_BURST: begin
        issue_d = issue_q + {{(CNT_W-1){1'b0}}, issue_en};
        ret_d   = ret_q + {{(CNT_W-1){1'b0}}, mem_data_valid};
        // A dropped request ends the burst once every issued read has returned.
        if ((mem_data_valid && (ret_q == CNT_LAST)) ||
            (!granted_req && (ret_d == issue_d))) begin
          state_d = IDLE;
          issue_d = '0;
          ret_d   = '0;
        end
      end
      D_WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      issue_q  <= '0;
      ret_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      ret_q    <= ret_d;
      last_d_q <= last_d_d;
    end
  end

  // Outputs decode straight from state so returns reach the cache in the same cycle.
  always_comb begin
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    d_wr_ack     = 1'b0;
    case (state_q)
      I_BURST: begin
        mem_enable   = issue_en;
        mem_addr     = i_addr;
        i_data_valid = mem_data_valid;
      end
      D_BURST: begin
        mem_enable   = issue_en;
        mem_addr     = d_addr;
        d_data_valid = mem_data_valid;
      end
      D_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
        d_wr_ack   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a vector table for the I-cache fill and
// hand-written sequences for ties, writes, saturation and mid-burst reset.
module tb_cache_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int BL  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_data_valid;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_data_valid;
  logic          d_wr_ack;
  logic [DW-1:0] rdata;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_data_valid = 1'b0;

  cache_mem_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data_valid(d_data_valid), .d_wr_ack(d_wr_ack), .rdata(rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic ireq;
    logic mdv;
    logic en;
    logic idv;
    logic inb;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input logic en, input logic wr,
                         input logic idv, input logic ddv, input logic ack,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    chk($sformatf("%s.mem_enable", tag), {31'b0, mem_enable}, {31'b0, en});
    chk($sformatf("%s.mem_wr", tag), {31'b0, mem_wr}, {31'b0, wr});
    chk($sformatf("%s.i_valid", tag), {31'b0, i_data_valid}, {31'b0, idv});
    chk($sformatf("%s.d_valid", tag), {31'b0, d_data_valid}, {31'b0, ddv});
    chk($sformatf("%s.wr_ack", tag), {31'b0, d_wr_ack}, {31'b0, ack});
    chk($sformatf("%s.mem_addr", tag), {16'b0, mem_addr}, {16'b0, addr});
    chk($sformatf("%s.mem_wdata", tag), {16'b0, mem_wdata}, {16'b0, wd});
    chk($sformatf("%s.rdata", tag), {16'b0, rdata}, {16'b0, mem_rdata});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_data_valid = 1'b0;
    mem_rdata = 16'h5A5A;
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  // One IDLE cycle: memory untouched, nothing routed back.
  task automatic arb(input logic ir, input logic dr, input logic dw, input logic mdv);
    i_req = ir; d_req = dr; d_wr = dw; mem_data_valid = mdv;
    mem_rdata = DW'($urandom);
    #1;
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  // Full fill: request held until the 8th return, memory latency LAT.
  task automatic burst(input logic gi, input logic oreq, input logic owr);
    int   nen;
    logic mdv;
    nen = 0;
    for (int k = 0; k < BL + LAT; k++) begin
      mdv = (k >= LAT);
      if (gi) begin
        i_req = 1'b1; i_addr = 16'h0400 + AW'(2 * k);
        d_req = oreq; d_wr = owr;
      end else begin
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000 + AW'(k);
        i_req = oreq;
      end
      mem_data_valid = mdv;
      mem_rdata = DW'($urandom);
      #1;
      if (mem_enable) nen++;
      chk_out(gi ? "iburst" : "dburst", (k < BL), 1'b0, gi & mdv, ~gi & mdv, 1'b0,
              gi ? i_addr : d_addr, '0);
      @(negedge clk);
    end
    chk(gi ? "iburst.reads" : "dburst.reads", 32'(nen), 32'(BL));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   issued;
    logic mdv;

    //            ireq  mdv  en   idv  inb
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // I-only fill, spurious returns in IDLE, then a fresh grant
    do_reset();
    issued = 0;
    for (int r = 0; r < 18; r++) begin
      i_req = vec[r].ireq; d_req = 1'b0; d_wr = 1'b0;
      i_addr = 16'h0400 + AW'(2 * issued);
      mem_data_valid = vec[r].mdv;
      mem_rdata = DW'($urandom);
      #1;
      chk_out($sformatf("vec%0d", r), vec[r].en, 1'b0, vec[r].idv, 1'b0, 1'b0,
              vec[r].inb ? i_addr : '0, '0);
      if (vec[r].en) issued++;
      @(negedge clk);
    end

    // Ties alternate: D first out of reset, then I on the next tie
    do_reset();
    arb(1'b1, 1'b1, 1'b0, 1'b0);
    burst(1'b0, 1'b1, 1'b0);
    arb(1'b1, 1'b0, 1'b0, 1'b0);
    burst(1'b1, 1'b0, 1'b0);
    arb(1'b1, 1'b1, 1'b0, 1'b0);
    burst(1'b1, 1'b1, 1'b0);
    arb(1'b0, 1'b1, 1'b0, 1'b0);
    burst(1'b0, 1'b0, 1'b0);

    // D write waits behind an I burst
    do_reset();
    d_addr = 16'h1234; d_wdata = 16'hBEEF;
    arb(1'b1, 1'b0, 1'b0, 1'b0);
    burst(1'b1, 1'b1, 1'b1);
    arb(1'b0, 1'b1, 1'b1, 1'b0);
    i_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; mem_data_valid = 1'b0;
    #1;
    chk_out("dwrite", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
    @(negedge clk);
    arb(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after three returns of a D burst; late returns are dropped
    do_reset();
    arb(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      mdv = (k >= LAT);
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3000 + AW'(k);
      mem_data_valid = mdv;
      mem_rdata = DW'($urandom);
      #1;
      chk_out("rstburst", 1'b1, 1'b0, 1'b0, mdv, 1'b0, d_addr, '0);
      @(negedge clk);
    end
    mem_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) arb(1'b0, 1'b0, 1'b0, 1'b1);
    arb(1'b1, 1'b0, 1'b0, 1'b0);
    burst(1'b1, 1'b0, 1'b0);
    arb(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
